riscv_core_hazard_ctrl: RTL and testbench

- Parametrised successor hazard/forwarding controller for the RV64IMAC 5-stage core.
- Adds a register scoreboard for out-of-pipe long-latency (LL) producers (mul/div, AMO, dcache miss refill) with per-unit completion ports, an outstanding-op limiter and x0-safe load-use detection.
- Sits beside the pipeline registers; drives all per-stage stall, flush and forwarding selects.

---
 rtl/riscv_core_hazard_pkg.sv | 19 +
 rtl/riscv_core_scoreboard.sv | 73 +++++++
 rtl/riscv_core_hazard_ctrl.sv | 161 ++++++++++++++++
 tb/tb_riscv_core_hazard_ctrl.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_core_hazard_pkg.sv
// rtl/riscv_core_hazard_pkg.sv - shared types and constants for the hazard controller
package riscv_core_hazard_pkg;

  typedef enum logic [1:0] {
    FWD_RF  = 2'b00,
    FWD_WB  = 2'b01,
    FWD_MEM = 2'b10
  } fwd_sel_e;

  localparam logic [1:0] RESULTSRC_LOAD = 2'b01;

  typedef enum logic [1:0] {
    CAUSE_NONE       = 2'b00,
    CAUSE_FREEZE     = 2'b01,
    CAUSE_LOAD_USE   = 2'b10,
    CAUSE_SCOREBOARD = 2'b11
  } stall_cause_e;

endpackage

// File: rtl/riscv_core_scoreboard.sv
// rtl/riscv_core_scoreboard.sv - pending-register scoreboard and outstanding counter for long-latency ops
module riscv_core_scoreboard #(
  parameter  int NUM_REGS        = 32,
  parameter  int NUM_LL_UNITS    = 2,
  parameter  int MAX_OUTSTANDING = 4,
  localparam int REG_AW          = $clog2(NUM_REGS),
  localparam int CNT_W           = $clog2(MAX_OUTSTANDING + 1)
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           issue,
  input  logic [REG_AW-1:0]              issue_rd,
  input  logic [NUM_LL_UNITS-1:0]        done_valid,
  input  logic [NUM_LL_UNITS*REG_AW-1:0] done_rd,
  input  logic                           kill,
  input  logic [REG_AW-1:0]              rs1,
  input  logic [REG_AW-1:0]              rs2,
  input  logic [REG_AW-1:0]              rd,
  output logic                           rs1_hit,
  output logic                           rs2_hit,
  output logic                           rd_hit,
  output logic                           full
);

  logic [NUM_REGS-1:0] pending_q, pending_d;
  logic [CNT_W-1:0]    outstanding_q, outstanding_d;
  int                  done_cnt;
  int                  cnt_next;

  // The issuing register is only visible in pending_q next cycle, so bypass it here.
  assign rs1_hit = (rs1 != '0) && (pending_q[rs1] || (issue && (issue_rd == rs1)));
  assign rs2_hit = (rs2 != '0) && (pending_q[rs2] || (issue && (issue_rd == rs2)));
  assign rd_hit  = (rd  != '0) && (pending_q[rd]  || (issue && (issue_rd == rd)));
  assign full    = (outstanding_q == CNT_W'(MAX_OUTSTANDING));

  always_comb begin
    pending_d = pending_q;
    done_cnt  = 0;
    for (int k = 0; k < NUM_LL_UNITS; k++) begin
      if (done_valid[k]) begin
        pending_d[done_rd[k*REG_AW +: REG_AW]] = 1'b0;
        done_cnt = done_cnt + 1;
      end
    end
    // Applied after the clears so a same-cycle set on the same register wins.
    if (issue) begin
      pending_d[issue_rd] = 1'b1;
    end
    pending_d[0] = 1'b0;

    cnt_next = int'(outstanding_q) + int'(issue) - done_cnt;
    if (cnt_next < 0) begin
      cnt_next = 0;
    end
    outstanding_d = CNT_W'(cnt_next);

    if (kill) begin
      pending_d     = '0;
      outstanding_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pending_q     <= '0;
      outstanding_q <= '0;
    end else begin
      pending_q     <= pending_d;
      outstanding_q <= outstanding_d;
    end
  end

endmodule

// File: rtl/riscv_core_hazard_ctrl.sv
// rtl/riscv_core_hazard_ctrl.sv - stall/flush/forwarding control with LL scoreboard; HAZARD_CTRL_PERF_EN adds perf counters
module riscv_core_hazard_ctrl
  import riscv_core_hazard_pkg::*;
#(
  parameter  int NUM_REGS        = 32,
  parameter  int NUM_LL_UNITS    = 2,
  parameter  int MAX_OUTSTANDING = 4,
  localparam int REG_AW          = $clog2(NUM_REGS)
) (
  input  logic                           i_hazard_ctrl_clk,
  input  logic                           i_hazard_ctrl_rst,
  input  logic [REG_AW-1:0]              i_hazard_ctrl_rs1_id,
  input  logic [REG_AW-1:0]              i_hazard_ctrl_rs2_id,
  input  logic [REG_AW-1:0]              i_hazard_ctrl_rd_id,
  input  logic                           i_hazard_ctrl_regwrite_id,
  input  logic [REG_AW-1:0]              i_hazard_ctrl_rs1_ex,
  input  logic [REG_AW-1:0]              i_hazard_ctrl_rs2_ex,
  input  logic [REG_AW-1:0]              i_hazard_ctrl_rd_ex,
  input  logic [REG_AW-1:0]              i_hazard_ctrl_rd_mem,
  input  logic [REG_AW-1:0]              i_hazard_ctrl_rd_wb,
  input  logic                           i_hazard_ctrl_regwrite_mem,
  input  logic                           i_hazard_ctrl_regwrite_wb,
  input  logic [1:0]                     i_hazard_ctrl_resultsrc_ex,
  input  logic                           i_hazard_ctrl_pcsrc_ex,
  input  logic                           i_hazard_ctrl_ll_ex,
  input  logic [NUM_LL_UNITS-1:0]        i_hazard_ctrl_ll_done_valid,
  input  logic [NUM_LL_UNITS*REG_AW-1:0] i_hazard_ctrl_ll_done_rd,
  input  logic                           i_hazard_ctrl_ll_kill,
  input  logic                           i_hazard_ctrl_icache_stall,
  input  logic                           i_hazard_ctrl_dcache_stall,
  input  logic                           i_hazard_ctrl_uart_stall,
  input  logic                           i_hazard_ctrl_csr_flush_id,
  input  logic                           i_hazard_ctrl_csr_flush_ex,
  input  logic                           i_hazard_ctrl_csr_flush_mem,
  input  logic                           i_hazard_ctrl_csr_flush_wb,
  output logic [1:0]                     o_hazard_ctrl_forwarda_ex,
  output logic [1:0]                     o_hazard_ctrl_forwardb_ex,
  output logic                           o_hazard_ctrl_stall_if,
  output logic                           o_hazard_ctrl_stall_id,
  output logic                           o_hazard_ctrl_stall_ex,
  output logic                           o_hazard_ctrl_stall_mem,
  output logic                           o_hazard_ctrl_stall_wb,
  output logic                           o_hazard_ctrl_flush_id,
  output logic                           o_hazard_ctrl_flush_ex,
  output logic                           o_hazard_ctrl_flush_mem,
  output logic                           o_hazard_ctrl_flush_wb,
  output logic                           o_hazard_ctrl_ll_issue
`ifdef HAZARD_CTRL_PERF_EN
  ,
  output logic [31:0]                    o_hazard_ctrl_perf_lu,
  output logic [31:0]                    o_hazard_ctrl_perf_sb,
  output logic [31:0]                    o_hazard_ctrl_perf_frz
`endif
);

  logic freeze, load_use, sb_full, ll_full, ll_issue, sb_hit, id_hazard;
  logic rs1_hit, rs2_hit, rd_hit;

  function automatic fwd_sel_e fwd_sel(input logic [REG_AW-1:0] rs,
                                       input logic [REG_AW-1:0] rd_mem,
                                       input logic              we_mem,
                                       input logic [REG_AW-1:0] rd_wb,
                                       input logic              we_wb);
    if (rs == '0)                   return FWD_RF;
    if (we_mem && (rd_mem == rs))   return FWD_MEM;
    if (we_wb && (rd_wb == rs))     return FWD_WB;
    return FWD_RF;
  endfunction

  assign o_hazard_ctrl_forwarda_ex = fwd_sel(i_hazard_ctrl_rs1_ex, i_hazard_ctrl_rd_mem,
                                             i_hazard_ctrl_regwrite_mem, i_hazard_ctrl_rd_wb,
                                             i_hazard_ctrl_regwrite_wb);
  assign o_hazard_ctrl_forwardb_ex = fwd_sel(i_hazard_ctrl_rs2_ex, i_hazard_ctrl_rd_mem,
                                             i_hazard_ctrl_regwrite_mem, i_hazard_ctrl_rd_wb,
                                             i_hazard_ctrl_regwrite_wb);

  assign freeze   = i_hazard_ctrl_icache_stall | i_hazard_ctrl_dcache_stall | i_hazard_ctrl_uart_stall;
  assign load_use = (i_hazard_ctrl_resultsrc_ex == RESULTSRC_LOAD) && (i_hazard_ctrl_rd_ex != '0) &&
                    ((i_hazard_ctrl_rd_ex == i_hazard_ctrl_rs1_id) ||
                     (i_hazard_ctrl_rd_ex == i_hazard_ctrl_rs2_id));
  assign ll_full  = i_hazard_ctrl_ll_ex & sb_full;
  assign ll_issue = i_hazard_ctrl_ll_ex & ~sb_full & ~freeze & ~i_hazard_ctrl_pcsrc_ex &
                    ~i_hazard_ctrl_csr_flush_ex & (i_hazard_ctrl_rd_ex != '0);
  assign o_hazard_ctrl_ll_issue = ll_issue;

  riscv_core_scoreboard #(
    .NUM_REGS        (NUM_REGS),
    .NUM_LL_UNITS    (NUM_LL_UNITS),
    .MAX_OUTSTANDING (MAX_OUTSTANDING)
  ) u_scoreboard (
    .clk        (i_hazard_ctrl_clk),
    .rst        (i_hazard_ctrl_rst),
    .issue      (ll_issue),
    .issue_rd   (i_hazard_ctrl_rd_ex),
    .done_valid (i_hazard_ctrl_ll_done_valid),
    .done_rd    (i_hazard_ctrl_ll_done_rd),
    .kill       (i_hazard_ctrl_ll_kill),
    .rs1        (i_hazard_ctrl_rs1_id),
    .rs2        (i_hazard_ctrl_rs2_id),
    .rd         (i_hazard_ctrl_rd_id),
    .rs1_hit    (rs1_hit),
    .rs2_hit    (rs2_hit),
    .rd_hit     (rd_hit),
    .full       (sb_full)
  );

  // rd only matters for writing instructions (WAW against an in-flight LL result).
  assign sb_hit    = rs1_hit | rs2_hit | (rd_hit & i_hazard_ctrl_regwrite_id);
  assign id_hazard = load_use | sb_hit;

  assign o_hazard_ctrl_stall_if  = freeze | (id_hazard & ~i_hazard_ctrl_pcsrc_ex) | ll_full;
  assign o_hazard_ctrl_stall_id  = o_hazard_ctrl_stall_if;
  assign o_hazard_ctrl_stall_ex  = freeze | ll_full;
  assign o_hazard_ctrl_stall_mem = freeze;
  assign o_hazard_ctrl_stall_wb  = freeze;

  assign o_hazard_ctrl_flush_id  = i_hazard_ctrl_pcsrc_ex | i_hazard_ctrl_csr_flush_id;
  assign o_hazard_ctrl_flush_ex  = i_hazard_ctrl_csr_flush_ex | i_hazard_ctrl_pcsrc_ex |
                                   (id_hazard & ~freeze & ~ll_full);
  assign o_hazard_ctrl_flush_mem = i_hazard_ctrl_csr_flush_mem | (ll_full & ~freeze);
  assign o_hazard_ctrl_flush_wb  = i_hazard_ctrl_csr_flush_wb;

`ifdef HAZARD_CTRL_PERF_EN
  stall_cause_e cause;
  logic [31:0]  perf_lu_q, perf_lu_d, perf_sb_q, perf_sb_d, perf_frz_q, perf_frz_d;

  // Each cycle is attributed to one cause; a freeze masks the ID-stage causes.
  always_comb begin
    cause = CAUSE_NONE;
    if (freeze)                                         cause = CAUSE_FREEZE;
    else if (load_use && !i_hazard_ctrl_pcsrc_ex)       cause = CAUSE_LOAD_USE;
    else if ((sb_hit && !i_hazard_ctrl_pcsrc_ex) || ll_full) cause = CAUSE_SCOREBOARD;
  end

  always_comb begin
    perf_lu_d  = perf_lu_q;
    perf_sb_d  = perf_sb_q;
    perf_frz_d = perf_frz_q;
    if (cause == CAUSE_LOAD_USE   && perf_lu_q  != 32'hFFFF_FFFF) perf_lu_d  = perf_lu_q + 32'd1;
    if (cause == CAUSE_SCOREBOARD && perf_sb_q  != 32'hFFFF_FFFF) perf_sb_d  = perf_sb_q + 32'd1;
    if (cause == CAUSE_FREEZE     && perf_frz_q != 32'hFFFF_FFFF) perf_frz_d = perf_frz_q + 32'd1;
  end

  always_ff @(posedge i_hazard_ctrl_clk) begin
    if (i_hazard_ctrl_rst) begin
      perf_lu_q  <= '0;
      perf_sb_q  <= '0;
      perf_frz_q <= '0;
    end else begin
      perf_lu_q  <= perf_lu_d;
      perf_sb_q  <= perf_sb_d;
      perf_frz_q <= perf_frz_d;
    end
  end

  assign o_hazard_ctrl_perf_lu  = perf_lu_q;
  assign o_hazard_ctrl_perf_sb  = perf_sb_q;
  assign o_hazard_ctrl_perf_frz = perf_frz_q;
`endif

endmodule

// File: tb/tb_riscv_core_hazard_ctrl.sv
// tb/tb_riscv_core_hazard_ctrl.sv - scoreboard bench for riscv_core_hazard_ctrl against a set/counter reference model
module tb_riscv_core_hazard_ctrl;

  localparam int NR = 32;
  localparam int NU = 2;
  localparam int MO = 4;
  localparam int AW = 5;

  logic          clk = 1'b0;
  logic          rst;
  logic [AW-1:0] rs1_id, rs2_id, rd_id, rs1_ex, rs2_ex, rd_ex, rd_mem, rd_wb;
  logic          regwrite_id, regwrite_mem, regwrite_wb, pcsrc_ex, ll_ex, ll_kill;
  logic [1:0]    resultsrc_ex;
  logic [NU-1:0] done_valid;
  logic [NU*AW-1:0] done_rd;
  logic          icache_stall, dcache_stall, uart_stall;
  logic          csr_id, csr_ex, csr_mem, csr_wb;

  logic [1:0] fwda, fwdb;
  logic       st_if, st_id, st_ex, st_mem, st_wb;
  logic       fl_id, fl_ex, fl_mem, fl_wb;
  logic       ll_issue;

  always #5 clk = ~clk;

  riscv_core_hazard_ctrl #(.NUM_REGS(NR), .NUM_LL_UNITS(NU), .MAX_OUTSTANDING(MO)) dut (
    .i_hazard_ctrl_clk           (clk),
    .i_hazard_ctrl_rst           (rst),
    .i_hazard_ctrl_rs1_id        (rs1_id),
    .i_hazard_ctrl_rs2_id        (rs2_id),
    .i_hazard_ctrl_rd_id         (rd_id),
    .i_hazard_ctrl_regwrite_id   (regwrite_id),
    .i_hazard_ctrl_rs1_ex        (rs1_ex),
    .i_hazard_ctrl_rs2_ex        (rs2_ex),
    .i_hazard_ctrl_rd_ex         (rd_ex),
    .i_hazard_ctrl_rd_mem        (rd_mem),
    .i_hazard_ctrl_rd_wb         (rd_wb),
    .i_hazard_ctrl_regwrite_mem  (regwrite_mem),
    .i_hazard_ctrl_regwrite_wb   (regwrite_wb),
    .i_hazard_ctrl_resultsrc_ex  (resultsrc_ex),
    .i_hazard_ctrl_pcsrc_ex      (pcsrc_ex),
    .i_hazard_ctrl_ll_ex         (ll_ex),
    .i_hazard_ctrl_ll_done_valid (done_valid),
    .i_hazard_ctrl_ll_done_rd    (done_rd),
    .i_hazard_ctrl_ll_kill       (ll_kill),
    .i_hazard_ctrl_icache_stall  (icache_stall),
    .i_hazard_ctrl_dcache_stall  (dcache_stall),
    .i_hazard_ctrl_uart_stall    (uart_stall),
    .i_hazard_ctrl_csr_flush_id  (csr_id),
    .i_hazard_ctrl_csr_flush_ex  (csr_ex),
    .i_hazard_ctrl_csr_flush_mem (csr_mem),
    .i_hazard_ctrl_csr_flush_wb  (csr_wb),
    .o_hazard_ctrl_forwarda_ex   (fwda),
    .o_hazard_ctrl_forwardb_ex   (fwdb),
    .o_hazard_ctrl_stall_if      (st_if),
    .o_hazard_ctrl_stall_id      (st_id),
    .o_hazard_ctrl_stall_ex      (st_ex),
    .o_hazard_ctrl_stall_mem     (st_mem),
    .o_hazard_ctrl_stall_wb      (st_wb),
    .o_hazard_ctrl_flush_id      (fl_id),
    .o_hazard_ctrl_flush_ex      (fl_ex),
    .o_hazard_ctrl_flush_mem     (fl_mem),
    .o_hazard_ctrl_flush_wb      (fl_wb),
    .o_hazard_ctrl_ll_issue      (ll_issue)
  );

  typedef struct {
    int         step;
    logic [1:0] fa;
    logic [1:0] fb;
    logic [4:0] stall;
    logic [3:0] flush;
    logic       issue;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   failures = 0;
  int   step_no = 0;

  bit   pend_m [NR];
  int   outs_m = 0;

  task automatic check(string nm, int step, logic [31:0] act, logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s step=%0d actual=%0h expected=%0h", nm, step, act, req);
    end
  endtask

  function automatic bit busy(int r, bit iss);
    return (r != 0) && (pend_m[r] || (iss && r == int'(rd_ex)));
  endfunction

  function automatic logic [1:0] fwd_m(int rs);
    if (rs == 0) return 2'b00;
    if (regwrite_mem && int'(rd_mem) == rs) return 2'b10;
    if (regwrite_wb && int'(rd_wb) == rs) return 2'b01;
    return 2'b00;
  endfunction

  task automatic idle();
    rst = 0; rs1_id = 0; rs2_id = 0; rd_id = 0; regwrite_id = 0;
    rs1_ex = 0; rs2_ex = 0; rd_ex = 0; rd_mem = 0; rd_wb = 0;
    regwrite_mem = 0; regwrite_wb = 0; resultsrc_ex = 0; pcsrc_ex = 0;
    ll_ex = 0; done_valid = 0; done_rd = 0; ll_kill = 0;
    icache_stall = 0; dcache_stall = 0; uart_stall = 0;
    csr_id = 0; csr_ex = 0; csr_mem = 0; csr_wb = 0;
  endtask

  // Predict this cycle's outputs from the model, then advance the model across the next edge.
  task automatic apply();
    exp_t e;
    bit frz, lu, full_m, iss, hit, stall_front;
    int ndone;
    frz    = icache_stall || dcache_stall || uart_stall;
    lu     = resultsrc_ex == 2'b01 && rd_ex != 0 && (rd_ex == rs1_id || rd_ex == rs2_id);
    full_m = ll_ex && outs_m == MO;
    iss    = ll_ex && outs_m < MO && !frz && !pcsrc_ex && !csr_ex && rd_ex != 0;
    hit    = busy(int'(rs1_id), iss) || busy(int'(rs2_id), iss) ||
             (regwrite_id && busy(int'(rd_id), iss));
    stall_front = frz || ((lu || hit) && !pcsrc_ex) || full_m;
    e.step  = step_no;
    e.fa    = fwd_m(int'(rs1_ex));
    e.fb    = fwd_m(int'(rs2_ex));
    e.stall = {stall_front, stall_front, frz || full_m, frz, frz};
    e.flush = {pcsrc_ex || csr_id,
               csr_ex || pcsrc_ex || ((lu || hit) && !frz && !full_m),
               csr_mem || (full_m && !frz),
               csr_wb};
    e.issue = iss;
    exp_q.push_back(e);

    if (rst || ll_kill) begin
      foreach (pend_m[i]) pend_m[i] = 0;
      outs_m = 0;
    end else begin
      ndone = 0;
      for (int k = 0; k < NU; k++) begin
        if (done_valid[k]) begin
          pend_m[int'(done_rd[k*AW +: AW])] = 0;
          ndone++;
        end
      end
      if (iss) pend_m[int'(rd_ex)] = 1;
      outs_m = outs_m + int'(iss) - ndone;
      if (outs_m < 0) outs_m = 0;
    end
    step_no++;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [AW-1:0] rreg();
    if ($urandom_range(0, 3) == 0) return AW'($urandom_range(0, NR - 1));
    return AW'($urandom_range(0, 7));
  endfunction

  function automatic bit chance(int pct);
    return $urandom_range(0, 99) < pct;
  endfunction

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("forwarda", e.step, 32'(fwda), 32'(e.fa));
        check("forwardb", e.step, 32'(fwdb), 32'(e.fb));
        check("stall", e.step, 32'({st_if, st_id, st_ex, st_mem, st_wb}), 32'(e.stall));
        check("flush", e.step, 32'({fl_id, fl_ex, fl_mem, fl_wb}), 32'(e.flush));
        check("ll_issue", e.step, 32'(ll_issue), 32'(e.issue));
      end
    end
  end

  initial begin : stimulus
    idle();
    rst = 1;
    repeat (2) @(posedge clk);
    #1;
    rst = 0;
    foreach (pend_m[i]) pend_m[i] = 0;
    outs_m = 0;

    apply();
    resultsrc_ex = 2'b01; rd_ex = 5; rs1_id = 5; rs2_id = 1; apply();
    rd_ex = 0; apply();

    idle(); rs1_ex = 7; rd_mem = 7; rd_wb = 7; regwrite_mem = 1; regwrite_wb = 1; apply();
    regwrite_mem = 0; apply();
    rs1_ex = 0; apply();

    idle(); ll_ex = 1; rd_ex = 10; apply();
    idle(); rs1_id = 10; apply(); apply();
    done_valid = 2'b10; done_rd = {5'd10, 5'd0}; apply();
    done_valid = 0; apply();
    idle(); ll_ex = 1; rd_ex = 10; apply();
    done_valid = 2'b10; done_rd = {5'd10, 5'd0}; apply();
    idle(); rs1_id = 10; apply();
    idle(); regwrite_id = 1; rd_id = 10; apply();

    idle(); ll_kill = 1; apply();
    idle(); apply();
    for (int i = 1; i <= 4; i++) begin
      idle(); ll_ex = 1; rd_ex = AW'(i); apply();
    end
    idle(); ll_ex = 1; rd_ex = 5; apply();
    done_valid = 2'b01; done_rd = {5'd0, 5'd1}; apply();
    done_valid = 0; apply();

    idle(); resultsrc_ex = 2'b01; rd_ex = 6; rs1_id = 6; pcsrc_ex = 1; apply();
    idle(); dcache_stall = 1; rs2_id = 3; apply();

    idle(); done_valid = 2'b01; done_rd = {5'd0, 5'd2}; apply();
    idle(); ll_kill = 1; apply();
    idle(); rs1_id = 3; rs2_id = 4; apply();
    idle(); ll_kill = 1; ll_ex = 1; rd_ex = 12; apply();
    idle(); rs1_id = 12; apply();

    idle(); ll_ex = 1; rd_ex = 9; apply();
    idle(); rs1_id = 9; rst = 1; apply();
    idle(); rs1_id = 9; apply();

    for (int n = 0; n < 2000; n++) begin
      rst          = chance(1);
      rs1_id       = rreg(); rs2_id = rreg(); rd_id = rreg();
      regwrite_id  = chance(60);
      rs1_ex       = rreg(); rs2_ex = rreg(); rd_ex = rreg();
      rd_mem       = rreg(); rd_wb = rreg();
      regwrite_mem = chance(60); regwrite_wb = chance(60);
      resultsrc_ex = 2'($urandom_range(0, 3));
      pcsrc_ex     = chance(10);
      ll_ex        = chance(50);
      done_valid   = {chance(25), chance(25)};
      done_rd      = {rreg(), rreg()};
      ll_kill      = chance(2);
      icache_stall = chance(5); dcache_stall = chance(5); uart_stall = chance(3);
      csr_id = chance(5); csr_ex = chance(5); csr_mem = chance(5); csr_wb = chance(5);
      apply();
    end

    idle();
    @(negedge clk);
    #1;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL drain pending=%0d expected=0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
